ub_tapped_delay_sr: RTL and testbench

Parametrised multi-tap circular-buffer delay line for unified-buffer shift-register links. One write stream enters; NTAPS read ports each present the input delayed by a per-tap, elaboration-time count of enabled cycles. It replaces the fixed-depth, single-tap, always-advancing delay modules in stencil pipelines, adding stall (`en`), working `flush`, multiple taps on shared storage, and optional fill-valid tracking.

---
 rtl/ub_tapped_delay_sr.sv | 106 ++++++++++
 tb/tb_ub_tapped_delay_sr.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/ub_tapped_delay_sr.sv
// Multi-tap circular-buffer delay line: one write stream, NTAPS read taps at fixed delays.
// Define UB_SR_VALID_EN to add fill tracking, per-tap valid and masking of unfilled taps.
module ub_tapped_delay_sr #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 68,
    parameter int NTAPS = 4,
    // Slice k (bits 16k+15:16k) is the delay of tap k; tap 0 = 1, tap 3 = 68.
    parameter logic [NTAPS*16-1:0] TAP_DELAYS = {16'd68, 16'd67, 16'd2, 16'd1}
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   en,
    input  logic [WIDTH-1:0]       in,
    output logic [NTAPS*WIDTH-1:0] tap_out,
    output logic [NTAPS-1:0]       tap_valid
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] DEPTH_W = (PW+1)'(DEPTH);

    if (DEPTH < 1) begin : g_bad_depth
        $error("ub_tapped_delay_sr: DEPTH must be at least 1");
    end
    if (NTAPS < 1) begin : g_bad_ntaps
        $error("ub_tapped_delay_sr: NTAPS must be at least 1");
    end

    logic [WIDTH-1:0] storage_q [DEPTH];
    logic [PW-1:0]    wp_q;
    logic [PW-1:0]    wp_d;

    always_comb begin
        wp_d = wp_q;
        if (flush) begin
            wp_d = '0;
        end else if (en) begin
            wp_d = (wp_q == PW'(DEPTH - 1)) ? '0 : wp_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q <= '0;
        end else begin
            wp_q <= wp_d;
        end
    end

    // Storage is deliberately not reset; flush leaves old data in place.
    always_ff @(posedge clk) begin
        if (en && !flush) begin
            storage_q[wp_q] <= in;
        end
    end

`ifdef UB_SR_VALID_EN
    localparam int FW = $clog2(DEPTH + 1);
    logic [FW-1:0] fill_q;
    logic [FW-1:0] fill_d;

    always_comb begin
        fill_d = fill_q;
        if (flush) begin
            fill_d = '0;
        end else if (en && (fill_q != FW'(DEPTH))) begin
            fill_d = fill_q + FW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_q <= '0;
        end else begin
            fill_q <= fill_d;
        end
    end
`endif

    for (genvar k = 0; k < NTAPS; k++) begin : g_tap
        localparam int DK = int'(TAP_DELAYS[16*k +: 16]);
        localparam logic [PW:0] DK_W = (PW+1)'(DK);

        logic [PW:0]      wpx;
        logic [PW-1:0]    rdIdx;
        logic [WIDTH-1:0] raw;

        if (DK < 1 || DK > DEPTH) begin : g_bad_delay
            $error("ub_tapped_delay_sr: tap delay out of range 1..DEPTH");
        end

        // One extra bit keeps wp+DEPTH-d from overflowing; d=DEPTH lands on wp (oldest entry).
        assign wpx   = {1'b0, wp_q};
        assign rdIdx = PW'((wpx >= DK_W) ? (wpx - DK_W) : (wpx + DEPTH_W - DK_W));
        assign raw   = storage_q[rdIdx];

`ifdef UB_SR_VALID_EN
        assign tap_valid[k]               = (fill_q >= FW'(DK));
        assign tap_out[k*WIDTH +: WIDTH]  = tap_valid[k] ? raw : '0;
`else
        assign tap_valid[k]               = 1'b1;
        assign tap_out[k*WIDTH +: WIDTH]  = raw;
`endif
    end

endmodule

// File: tb/tb_ub_tapped_delay_sr.sv
// Directed self-checking bench for ub_tapped_delay_sr (default 68-deep instance plus a 4-deep wrap instance).
// Expectations follow UB_SR_VALID_EN when it is defined for the build.
module tb_ub_tapped_delay_sr;

    logic        clk;
    logic        rst_n;
    logic        flushA, enA, flushB, enB;
    logic [15:0] inA, inB;
    logic [63:0] tapA, tapB;
    logic [3:0]  validA, validB;

    int compared   = 0;
    int mismatched = 0;

    ub_tapped_delay_sr dutA (
        .clk(clk), .rst_n(rst_n), .flush(flushA), .en(enA), .in(inA),
        .tap_out(tapA), .tap_valid(validA)
    );

    ub_tapped_delay_sr #(
        .WIDTH(16), .DEPTH(4), .NTAPS(4),
        .TAP_DELAYS({16'd4, 16'd3, 16'd2, 16'd1})
    ) dutB (
        .clk(clk), .rst_n(rst_n), .flush(flushB), .en(enB), .in(inB),
        .tap_out(tapB), .tap_valid(validB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive at the falling edge, let one rising edge happen, come back to the falling edge to observe.
    task automatic applyStimulus(input logic e, input logic [15:0] d, input logic f);
        enA = e; inA = d; flushA = f;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic applyStimulusWrap(input logic e, input logic [15:0] d);
        enB = e; inB = d; flushB = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Valid pattern for the default instance (delays 1,2,67,68) after c writes since reset/flush.
    function automatic logic [3:0] expValidA(input int c);
`ifdef UB_SR_VALID_EN
        expValidA = {c >= 68, c >= 67, c >= 2, c >= 1};
`else
        expValidA = (c >= 0) ? 4'hF : 4'h0;
`endif
    endfunction

    // After e enabled writes of 0,1,2,... tap with delay d shows e-d.
    initial begin
        int c;
        logic e;
        rst_n  = 1'b0;
        enA    = 1'b0; inA = '0; flushA = 1'b0;
        enB    = 1'b0; inB = '0; flushB = 1'b0;
        @(negedge clk);
        checkOutput("reset_validA", 64'(validA), 64'(expValidA(0)));
`ifdef UB_SR_VALID_EN
        checkOutput("reset_outA", tapA, 64'h0);
        checkOutput("reset_validB", 64'(validB), 64'h0);
`else
        checkOutput("reset_validB", 64'(validB), 64'hF);
`endif
        rst_n = 1'b1;

        for (int n = 0; n < 30; n++) begin
            applyStimulus(1'b1, 16'(n), 1'b0);
            checkOutput("pre_tap0", 64'(tapA[15:0]), 64'(n));
            checkOutput("pre_valid", 64'(validA), 64'(expValidA(n + 1)));
        end

        rst_n = 1'b0;
        #1;
        checkOutput("midreset_valid", 64'(validA), 64'(expValidA(0)));
`ifdef UB_SR_VALID_EN
        checkOutput("midreset_out", tapA, 64'h0);
`endif
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int n = 0; n < 68; n++) begin
            applyStimulus(1'b1, 16'(n), 1'b0);
            checkOutput("fill_tap0", 64'(tapA[15:0]), 64'(n));
            checkOutput("fill_valid", 64'(validA), 64'(expValidA(n + 1)));
            if (n == 1)  checkOutput("fill_tap1_first", 64'(tapA[31:16]), 64'h0);
            if (n == 66) checkOutput("fill_tap2_first", 64'(tapA[47:32]), 64'h0);
        end
        checkOutput("full_taps", tapA, 64'h0000_0001_0042_0043);

        applyStimulus(1'b0, 16'hBEEF, 1'b0);
        checkOutput("hold_taps", tapA, 64'h0000_0001_0042_0043);
        checkOutput("hold_valid", 64'(validA), 64'(expValidA(68)));

        // Flush with en high: the 0x3039 must not be written, and wp returns to 0.
        applyStimulus(1'b1, 16'h3039, 1'b1);
`ifdef UB_SR_VALID_EN
        checkOutput("flush_valid", 64'(validA), 64'h0);
        checkOutput("flush_out", tapA, 64'h0);
`else
        checkOutput("flush_valid", 64'(validA), 64'hF);
        checkOutput("flush_out", tapA, 64'h0000_0001_0042_0043);
`endif

        c = 0;
        for (int i = 0; i < 20; i++) begin
            e = (i % 2 == 0);
            applyStimulus(e, e ? 16'(c) : 16'hDEAD, 1'b0);
            if (e) c++;
            checkOutput("stall_tap0", 64'(tapA[15:0]), 64'(c - 1));
            checkOutput("stall_valid", 64'(validA), 64'(expValidA(c)));
        end
        checkOutput("stall_tap1", 64'(tapA[31:16]), 64'd8);

        enA = 1'b0;
        for (int n = 0; n < 20; n++) begin
            applyStimulusWrap(1'b1, 16'(n));
            if (n == 3) checkOutput("wrap_first_full", tapB, 64'h0000_0001_0002_0003);
        end
        checkOutput("wrap_taps", tapB, 64'h0010_0011_0012_0013);
        checkOutput("wrap_valid", 64'(validB), 64'hF);
        applyStimulusWrap(1'b0, 16'h7777);
        checkOutput("wrap_hold", tapB, 64'h0010_0011_0012_0013);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
